// File: rtl/regfile_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_bank                                                          |
// | RV32I architectural register file: 31x32 storage (x0 hardwired to 0), |
// | one synchronous write port, two combinational read ports with         |
// | optional same-cycle write-to-read bypass.                             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module regfile_bank #(
  parameter logic BYPASS = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic        i_rd_wren,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data
);

  localparam logic [4:0]  c_x0   = 5'd0;
  localparam logic [31:0] c_zero = 32'h0;

  logic [31:0] r_regs [1:31];
  logic [31:1] w_wr_onehot;
  logic        w_wr_live;
  logic [31:0] w_rs1_store;
  logic [31:0] w_rs2_store;

  // Live write only outside reset and never to x0; gates both storage and bypass.
  assign w_wr_live = i_reset && i_rd_wren && (i_rd_addr != c_x0);

  for (genvar i = 1; i < 32; i++) begin : g_wr_dec
    assign w_wr_onehot[i] = w_wr_live && (i_rd_addr == 5'(i));
  end

  always_ff @(posedge i_clk) begin
    for (int i = 1; i < 32; i++) begin
      if (!i_reset) begin
        r_regs[i] <= c_zero;
      end else if (w_wr_onehot[i]) begin
        r_regs[i] <= i_rd_data;
      end
    end
  end

  assign w_rs1_store = (i_rs1_addr == c_x0) ? c_zero : r_regs[i_rs1_addr];
  assign w_rs2_store = (i_rs2_addr == c_x0) ? c_zero : r_regs[i_rs2_addr];

  if (BYPASS) begin : g_bypass
    assign o_rs1_data = (w_wr_live && (i_rd_addr == i_rs1_addr)) ? i_rd_data : w_rs1_store;
    assign o_rs2_data = (w_wr_live && (i_rd_addr == i_rs2_addr)) ? i_rd_data : w_rs2_store;
  end else begin : g_no_bypass
    assign o_rs1_data = w_rs1_store;
    assign o_rs2_data = w_rs2_store;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_bank.sv
`default_nettype none
// Testbench for regfile_bank: two instances (bypass on/off) share stimulus;
// expected reads are queued per cycle and checked by a separate monitor.
module tb_regfile_bank;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] bp_rs1, bp_rs2, nb_rs1, nb_rs2;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [31:0] bp1;
    logic [31:0] bp2;
    logic [31:0] nb1;
    logic [31:0] nb2;
  } exp_t;

  exp_t sb_q[$];

  regfile_bank #(.BYPASS(1'b1)) u_bp (
    .i_clk(clk), .i_reset(rst_n),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .i_rd_wren(rd_wren), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_rs1_data(bp_rs1), .o_rs2_data(bp_rs2)
  );

  regfile_bank #(.BYPASS(1'b0)) u_nb (
    .i_clk(clk), .i_reset(rst_n),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .i_rd_wren(rd_wren), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_rs1_data(nb_rs1), .o_rs2_data(nb_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Monitor: mid-cycle sample of all four read ports against the queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, " bp.rs1"}, bp_rs1, e.bp1);
        chk({e.name, " bp.rs2"}, bp_rs2, e.bp2);
        chk({e.name, " nb.rs1"}, nb_rs1, e.nb1);
        chk({e.name, " nb.rs2"}, nb_rs2, e.nb2);
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic we,
                      input logic [4:0] rd, input logic [31:0] d,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] bp1, input logic [31:0] bp2,
                      input logic [31:0] nb1, input logic [31:0] nb2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; rd_wren = we; rd_addr = rd; rd_data = d;
    rs1_addr = a1; rs2_addr = a2;
    e.name = name; e.bp1 = bp1; e.bp2 = bp2; e.nb1 = nb1; e.nb2 = nb2;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] seqval(input int n);
    return (n == 0) ? 32'h0 : 32'h1000_0000 + 32'(n);
  endfunction

  initial begin
    int wait_cyc;
    rst_n = 1'b0; rd_wren = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0;

    step("x0_pre_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset_read",   0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    for (int n = 0; n < 32; n++)
      step("reset_sweep", 1, 0, 0, 0, 5'(n), 5'(31 - n), 0, 0, 0, 0);

    // Write x5, then reset wipes it.
    step("wr_x5", 1, 1, 5, 32'hDEADBEEF, 5, 0, 32'hDEADBEEF, 0, 0, 0);
    step("x5_in_reset", 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    step("x5_after_reset", 1, 0, 0, 0, 5, 5, 0, 0, 0, 0);

    // x0 writes discarded.
    step("wr_x0", 1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    step("x0_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fill all registers; bypass shows new data, storage still zero.
    for (int n = 1; n < 32; n++)
      step("fill", 1, 1, 5'(n), seqval(n), 5'(n), 0, seqval(n), 0, 0, 0);
    for (int n = 0; n < 32; n++)
      step("pair_read", 1, 0, 0, 0, 5'(n), 5'(31 - n),
           seqval(n), seqval(31 - n), seqval(n), seqval(31 - n));

    // Bypass on both ports.
    step("x7_init", 1, 1, 7, 32'h11111111, 0, 0, 0, 0, 0, 0);
    step("x7_bypass", 1, 1, 7, 32'h22222222, 7, 7,
         32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111);
    step("x7_after", 1, 0, 0, 0, 7, 7,
         32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);

    // Back-to-back writes to x3; rs2 unrelated must not bypass.
    step("b2b_1", 1, 1, 3, 32'hAAAA0001, 3, 4,
         32'hAAAA0001, seqval(4), seqval(3), seqval(4));
    step("b2b_2", 1, 1, 3, 32'hBBBB0002, 3, 4,
         32'hBBBB0002, seqval(4), 32'hAAAA0001, seqval(4));
    step("b2b_after", 1, 0, 0, 0, 3, 4,
         32'hBBBB0002, seqval(4), 32'hBBBB0002, seqval(4));

    // Reset collision: no bypass, write lost, all cleared.
    step("rst_collide", 0, 1, 9, 32'hCAFEF00D, 9, 9,
         seqval(9), seqval(9), seqval(9), seqval(9));
    step("x9_after", 1, 0, 0, 0, 9, 7, 0, 0, 0, 0);
    step("x31_after", 1, 0, 0, 0, 31, 3, 0, 0, 0, 0);

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
